// File: rtl/prbs_pkg.sv
// Shared definitions for the LFSR pattern generator and its receive-side checker.
// Keeping the taps here means both ends of the link always agree on the recurrence.
package prbs_pkg;

    localparam int PRBS_WIDTH = 4;
    localparam int PRBS_TAP_A = 2;
    localparam int PRBS_TAP_B = 1;

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } prbsState_e;

endpackage

// File: rtl/prbs_next.sv
// Combinational prediction of the next LFSR bit from the current shift register.
module prbs_next
    import prbs_pkg::*;
#(
    parameter int WIDTH = PRBS_WIDTH,
    parameter int TAP_A = PRBS_TAP_A,
    parameter int TAP_B = PRBS_TAP_B
) (
    input  logic [WIDTH-1:0] sr_i,
    output logic             exp_o
);

    assign exp_o = sr_i[TAP_A] ^ sr_i[TAP_B];

endmodule

// File: rtl/prbs_checker.sv
// Serial LFSR pattern checker: self-seeds from the received stream, then free-runs
// its own copy of the recurrence and reports per-bit errors, a saturating count and lock.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH       = PRBS_WIDTH,
    parameter int TAP_A       = PRBS_TAP_A,
    parameter int TAP_B       = PRBS_TAP_B,
    parameter int ERR_CNT_W   = 16,
    parameter int WINDOW      = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic                 in_bit,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 lock_lost
);

    localparam int SEED_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;

    localparam logic [SEED_W-1:0]    SEED_LAST = SEED_W'(WIDTH - 1);
    localparam logic [WIN_W-1:0]     WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0]    WERR_LAST = WERR_W'(LOSS_THRESH - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

    prbsState_e            state_q;
    logic [WIDTH-1:0]      sr_q;
    logic [SEED_W-1:0]     seedCnt_q;
    logic [WIN_W-1:0]      winCnt_q;
    logic [WERR_W-1:0]     winErr_q;
    logic                  locked_q;
    logic                  errPulse_q;
    logic [ERR_CNT_W-1:0]  errCount_q;
    logic                  lockLost_q;

    logic                  expBit;
    logic                  mismatch;
    logic [WIDTH-1:0]      srSeed_d;
    logic [WIDTH-1:0]      srCheck_d;

    prbs_next #(
        .WIDTH (WIDTH),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_next (
        .sr_i  (sr_q),
        .exp_o (expBit)
    );

    // While seeding the register takes the line; once locked it only takes its own prediction,
    // so one corrupted bit on the wire costs exactly one error.
    assign srSeed_d  = {sr_q[WIDTH-2:0], in_bit};
    assign srCheck_d = {sr_q[WIDTH-2:0], expBit};
    assign mismatch  = in_bit ^ expBit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEED;
            sr_q       <= '0;
            seedCnt_q  <= '0;
            winCnt_q   <= '0;
            winErr_q   <= '0;
            locked_q   <= 1'b0;
            errPulse_q <= 1'b0;
            errCount_q <= '0;
            lockLost_q <= 1'b0;
        end else begin
            errPulse_q <= 1'b0;
            lockLost_q <= 1'b0;
            if (clr) begin
                errCount_q <= '0;
            end
            if (in_valid) begin
                case (state_q)
                    SEED: begin
                        sr_q <= srSeed_d;
                        if (seedCnt_q == SEED_LAST) begin
                            seedCnt_q <= '0;
                            // An all-zero register would predict zeros forever, so reseed instead.
                            if (srSeed_d != '0) begin
                                state_q  <= CHECK;
                                locked_q <= 1'b1;
                                winCnt_q <= '0;
                                winErr_q <= '0;
                            end
                        end else begin
                            seedCnt_q <= seedCnt_q + 1'b1;
                        end
                    end
                    CHECK: begin
                        sr_q <= srCheck_d;
                        if (mismatch) begin
                            errPulse_q <= 1'b1;
                            if (!clr && errCount_q != ERR_MAX) begin
                                errCount_q <= errCount_q + 1'b1;
                            end
                        end
                        // The threshold test sees this bit's error before any end-of-window clear.
                        if (mismatch && winErr_q == WERR_LAST) begin
                            state_q    <= SEED;
                            locked_q   <= 1'b0;
                            lockLost_q <= 1'b1;
                            seedCnt_q  <= '0;
                            winCnt_q   <= '0;
                            winErr_q   <= '0;
                        end else if (winCnt_q == WIN_LAST) begin
                            winCnt_q <= '0;
                            winErr_q <= '0;
                        end else begin
                            winCnt_q <= winCnt_q + 1'b1;
                            winErr_q <= winErr_q + WERR_W'(mismatch);
                        end
                    end
                    default: state_q <= SEED;
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = errPulse_q;
    assign err_count = errCount_q;
    assign lock_lost = lockLost_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed/randomized bench for prbs_checker: a default instance and a small-counter,
// high-threshold instance share one input stream and are checked against a bit-history model.
module tb_prbs_checker;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        inValid;
    logic        inBit;

    logic        locked0, errPulse0, lockLost0;
    logic [15:0] errCount0;
    logic        locked1, errPulse1, lockLost1;
    logic [3:0]  errCount1;

    int checks;
    int errors;
    int gIdx;

    // Generator output after reset: x[n] = x[n-3] ^ x[n-2], period 7.
    localparam bit PATTERN [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam int M_WINDOW [2] = '{16, 16};
    localparam int M_THRESH [2] = '{4, 16};
    localparam int M_MAX    [2] = '{65535, 15};

    int mLocked  [2];
    int mSeedCnt [2];
    int mN       [2];
    int mWinPos  [2];
    int mWinErrs [2];
    int mCnt     [2];
    int mPulse   [2];
    int mLost    [2];
    bit mHist    [2][4];

    prbs_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (inValid),
        .in_bit    (inBit),
        .locked    (locked0),
        .err_pulse (errPulse0),
        .err_count (errCount0),
        .lock_lost (lockLost0)
    );

    prbs_checker #(
        .ERR_CNT_W   (4),
        .WINDOW      (16),
        .LOSS_THRESH (16)
    ) dutSat (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (inValid),
        .in_bit    (inBit),
        .locked    (locked1),
        .err_pulse (errPulse1),
        .err_count (errCount1),
        .lock_lost (lockLost1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit genBit(input int idx);
        return PATTERN[idx % 7];
    endfunction

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            mLocked[k] = 0; mSeedCnt[k] = 0; mN[k] = 0; mWinPos[k] = 0;
            mWinErrs[k] = 0; mCnt[k] = 0; mPulse[k] = 0; mLost[k] = 0;
            for (int j = 0; j < 4; j++) mHist[k][j] = 1'b0;
        end
    endtask

    task automatic modelStep(input int k, input bit v, input bit b, input bit c);
        bit e;
        mPulse[k] = 0;
        mLost[k]  = 0;
        if (c) mCnt[k] = 0;
        if (v) begin
            if (mLocked[k] == 0) begin
                mHist[k][mN[k] % 4] = b;
                mN[k]++;
                mSeedCnt[k]++;
                if (mSeedCnt[k] == 4) begin
                    mSeedCnt[k] = 0;
                    if (mHist[k][0] | mHist[k][1] | mHist[k][2] | mHist[k][3]) begin
                        mLocked[k] = 1; mWinPos[k] = 0; mWinErrs[k] = 0;
                    end
                end
            end else begin
                e = mHist[k][(mN[k] - 2) % 4] ^ mHist[k][(mN[k] - 3) % 4];
                mHist[k][mN[k] % 4] = e;
                mN[k]++;
                if (b != e) begin
                    mPulse[k] = 1;
                    if (!c && mCnt[k] < M_MAX[k]) mCnt[k]++;
                    mWinErrs[k]++;
                end
                if (mWinErrs[k] == M_THRESH[k]) begin
                    mLocked[k] = 0; mLost[k] = 1; mSeedCnt[k] = 0;
                    mWinPos[k] = 0; mWinErrs[k] = 0;
                end else if (mWinPos[k] == M_WINDOW[k] - 1) begin
                    mWinPos[k] = 0; mWinErrs[k] = 0;
                end else begin
                    mWinPos[k]++;
                end
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkVal("main.locked",    32'(locked0),   32'(mLocked[0]));
        checkVal("main.errPulse",  32'(errPulse0), 32'(mPulse[0]));
        checkVal("main.errCount",  32'(errCount0), 32'(mCnt[0]));
        checkVal("main.lockLost",  32'(lockLost0), 32'(mLost[0]));
        checkVal("sat.locked",     32'(locked1),   32'(mLocked[1]));
        checkVal("sat.errPulse",   32'(errPulse1), 32'(mPulse[1]));
        checkVal("sat.errCount",   32'(errCount1), 32'(mCnt[1]));
        checkVal("sat.lockLost",   32'(lockLost1), 32'(mLost[1]));
    endtask

    task automatic applyStimulus(input bit v, input bit b, input bit c);
        inValid = v;
        inBit   = b;
        clr     = c;
        @(posedge clk);
        modelStep(0, v, b, c);
        modelStep(1, v, b, c);
        #1;
        checkOutput();
    endtask

    task automatic sendBit(input bit flip, input bit c);
        applyStimulus(1'b1, genBit(gIdx) ^ flip, c);
        gIdx++;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        resetModel();
        gIdx = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int  validCnt;
        bit  done;
        bit  v;
        checks  = 0;
        errors  = 0;
        gIdx    = 0;
        clr     = 1'b0;
        inValid = 1'b0;
        inBit   = 1'b0;
        rst_n   = 1'b0;
        resetModel();
        #2;
        checkVal("reset.locked",   32'(locked0),   0);
        checkVal("reset.errPulse", 32'(errPulse0), 0);
        checkVal("reset.errCount", 32'(errCount0), 0);
        checkVal("reset.lockLost", 32'(lockLost0), 0);

        $display("[TB] clean lock");
        doReset();
        for (int i = 0; i < 200; i++) begin
            sendBit(1'b0, 1'b0);
            if (i == 2) checkVal("clean.notYetLocked", 32'(locked0), 0);
            if (i == 3) checkVal("clean.lockPoint", 32'(locked0), 1);
            checkVal("clean.noErr", 32'(errPulse0), 0);
        end
        checkVal("clean.errCount", 32'(errCount0), 0);

        $display("[TB] single bit error");
        sendBit(1'b1, 1'b0);
        checkVal("single.errPulse", 32'(errPulse0), 1);
        checkVal("single.errCount", 32'(errCount0), 1);
        checkVal("single.locked",   32'(locked0),   1);
        sendBit(1'b0, 1'b0);
        checkVal("single.pulseOnce", 32'(errPulse0), 0);

        $display("[TB] loss of lock and relock");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkVal("loss.clr", 32'(errCount0), 0);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (mWinPos[0] == 0) done = 1'b1;
            else sendBit(1'b0, 1'b0);
        end
        checkVal("loss.windowAligned", 32'(done), 1);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        checkVal("loss.stillLocked", 32'(locked0), 1);
        sendBit(1'b1, 1'b0);
        checkVal("loss.lockLost", 32'(lockLost0), 1);
        checkVal("loss.unlocked", 32'(locked0),   0);
        checkVal("loss.errCount", 32'(errCount0), 4);
        for (int i = 0; i < 4; i++) begin
            sendBit(1'b0, 1'b0);
            checkVal("relock.lockedAt", 32'(locked0), (i == 3) ? 1 : 0);
        end
        checkVal("relock.errCount", 32'(errCount0), 4);

        $display("[TB] three errors per window");
        for (int i = 0; i < 96; i++) begin
            sendBit((mWinPos[0] == 1 || mWinPos[0] == 6 || mWinPos[0] == 11), 1'b0);
            checkVal("three.locked", 32'(locked0), 1);
        end

        $display("[TB] valid gaps");
        doReset();
        validCnt = 0;
        for (int i = 0; i < 150; i++) begin
            v = 1'b1 & $urandom_range(0, 1);
            if (v) begin
                sendBit(1'b0, 1'b0);
                validCnt++;
                if (validCnt == 4) checkVal("gap.lockPoint", 32'(locked0), 1);
            end else begin
                applyStimulus(1'b0, 1'b1 & $urandom, 1'b0);
            end
        end
        checkVal("gap.errCount", 32'(errCount0), 0);
        checkVal("gap.locked",   32'(locked0),   1);

        $display("[TB] saturation and clear");
        for (int i = 0; i < 40; i++) sendBit(1'b1, 1'b0);
        checkVal("sat.sticks", 32'(errCount1), 15);
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (mLocked[0] != 0) begin
                sendBit(1'b1, 1'b1);
                checkVal("clrErr.pulse", 32'(errPulse0), 1);
                checkVal("clrErr.count", 32'(errCount0), 0);
                done = 1'b1;
            end else begin
                sendBit(1'b1, 1'b0);
            end
        end
        checkVal("clrErr.reached", 32'(done), 1);

        $display("[TB] reset mid-check and lockup pattern");
        doReset();
        for (int i = 0; i < 10; i++) sendBit(1'b1 & $urandom_range(0, 1) & (i == 7), 1'b0);
        inValid = 1'b1;
        inBit   = 1'b1;
        #2;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkVal("midReset.locked",   32'(locked0),   0);
        checkVal("midReset.errCount", 32'(errCount0), 0);
        checkVal("midReset.errPulse", 32'(errPulse0), 0);
        checkVal("midReset.satCount", 32'(errCount1), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkVal("lockup.locked", 32'(locked0), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
